// File: rtl/hex_dump_sequencer.sv
// Walks a bank of words MSB-byte-first through one shared byte-to-hex converter
// and writes the two resulting characters per byte into a text buffer.
module hex_dump_sequencer #(
  parameter int NUM_WORDS   = 32,
  parameter int WORD_W      = 32,
  parameter int IDX_W       = 5,
  parameter int CHAR_ADDR_W = 10,
  parameter int BASE_ADDR   = 0,
  parameter int LINE_STRIDE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   hex_en,
  output logic                   busy,
  output logic                   done,
  output logic                   word_rd_en,
  output logic [IDX_W-1:0]       word_addr,
  input  logic [WORD_W-1:0]      word_data,
  output logic [7:0]             conv_bin,
  output logic                   conv_en,
  input  logic [15:0]            conv_ascii,
  output logic                   char_we,
  output logic [CHAR_ADDR_W-1:0] char_addr,
  output logic [7:0]             char_data,
  input  logic                   char_ready
);

  localparam int NBYTES = WORD_W / 8;
  localparam int B_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [B_W-1:0]         LAST_B   = B_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0]       LAST_W   = IDX_W'(NUM_WORDS - 1);
  localparam logic [CHAR_ADDR_W-1:0] BASE_A   = CHAR_ADDR_W'(BASE_ADDR);
  localparam logic [CHAR_ADDR_W-1:0] STRIDE_A = CHAR_ADDR_W'(LINE_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_EMIT_HI, S_EMIT_LO, S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [IDX_W-1:0]         r_w;
  logic [B_W-1:0]           r_b;
  logic [WORD_W-1:0]        r_shift;
  logic                     r_hex_en;
  logic [CHAR_ADDR_W-1:0]   r_line_addr;
  logic [CHAR_ADDR_W-1:0]   r_char_addr;

  // Character address is tracked incrementally (line base + running offset)
  // instead of computing BASE + w*STRIDE + 2*b with a multiplier; the modulo
  // 2**CHAR_ADDR_W wrap falls out of the register width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_b         <= '0;
      r_shift     <= '0;
      r_hex_en    <= 1'b0;
      r_line_addr <= '0;
      r_char_addr <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hex_en    <= hex_en;
            r_w         <= '0;
            r_b         <= '0;
            r_line_addr <= BASE_A;
            r_char_addr <= BASE_A;
          end
        end
        S_LATCH: r_shift <= word_data;
        S_EMIT_HI: begin
          if (char_ready) r_char_addr <= r_char_addr + CHAR_ADDR_W'(1);
        end
        S_EMIT_LO: begin
          if (char_ready) begin
            if (r_b < LAST_B) begin
              r_b         <= r_b + B_W'(1);
              r_shift     <= r_shift << 8;
              r_char_addr <= r_char_addr + CHAR_ADDR_W'(1);
            end else if (r_w < LAST_W) begin
              r_w         <= r_w + IDX_W'(1);
              r_b         <= '0;
              r_line_addr <= r_line_addr + STRIDE_A;
              r_char_addr <= r_line_addr + STRIDE_A;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    word_rd_en = 1'b0;
    word_addr  = '0;
    conv_bin   = '0;
    char_we    = 1'b0;
    char_addr  = '0;
    char_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        word_rd_en = 1'b1;
        word_addr  = r_w;
        w_next     = S_LATCH;
      end
      S_LATCH: w_next = S_EMIT_HI;
      S_EMIT_HI: begin
        conv_bin  = r_shift[WORD_W-1 -: 8];
        char_we   = 1'b1;
        char_addr = r_char_addr;
        char_data = conv_ascii[15:8];
        if (char_ready) w_next = S_EMIT_LO;
      end
      S_EMIT_LO: begin
        conv_bin  = r_shift[WORD_W-1 -: 8];
        char_we   = 1'b1;
        char_addr = r_char_addr;
        char_data = conv_ascii[7:0];
        if (char_ready) begin
          if (r_b < LAST_B)      w_next = S_EMIT_HI;
          else if (r_w < LAST_W) w_next = S_FETCH;
          else                   w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign conv_en = r_hex_en;

endmodule

// File: tb/tb_hex_dump_sequencer.sv
// Directed bench for hex_dump_sequencer: two words, hex/raw modes, stall,
// ignored restart, mid-run reset and text-buffer address wrap.
module tb_hex_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hex_en = 1'b0;
  logic        char_ready = 1'b1;

  logic        busy, done, word_rd_en, conv_en, char_we;
  logic [0:0]  word_addr;
  logic [31:0] word_data;
  logic [7:0]  conv_bin, char_data;
  logic [15:0] conv_ascii;
  logic [9:0]  char_addr;

  logic        x_busy, x_done, x_word_rd_en, x_conv_en, x_char_we;
  logic [0:0]  x_word_addr;
  logic [31:0] x_word_data;
  logic [7:0]  x_conv_bin, x_char_data;
  logic [15:0] x_conv_ascii;
  logic [9:0]  x_char_addr;

  logic [31:0] mem [2];

  always #5 clk = ~clk;

  hex_dump_sequencer #(.NUM_WORDS(2), .WORD_W(32), .IDX_W(1), .CHAR_ADDR_W(10),
                       .BASE_ADDR(0), .LINE_STRIDE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hex_en(hex_en),
    .busy(busy), .done(done), .word_rd_en(word_rd_en), .word_addr(word_addr),
    .word_data(word_data), .conv_bin(conv_bin), .conv_en(conv_en),
    .conv_ascii(conv_ascii), .char_we(char_we), .char_addr(char_addr),
    .char_data(char_data), .char_ready(char_ready));

  // Base near the top of the 1024-entry buffer so word0 straddles the wrap.
  hex_dump_sequencer #(.NUM_WORDS(2), .WORD_W(32), .IDX_W(1), .CHAR_ADDR_W(10),
                       .BASE_ADDR(1020), .LINE_STRIDE(16)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .hex_en(hex_en),
    .busy(x_busy), .done(x_done), .word_rd_en(x_word_rd_en), .word_addr(x_word_addr),
    .word_data(x_word_data), .conv_bin(x_conv_bin), .conv_en(x_conv_en),
    .conv_ascii(x_conv_ascii), .char_we(x_char_we), .char_addr(x_char_addr),
    .char_data(x_char_data), .char_ready(char_ready));

  always_ff @(posedge clk) begin
    if (word_rd_en)   word_data   <= mem[word_addr];
    if (x_word_rd_en) x_word_data <= mem[x_word_addr];
  end

  function automatic logic [7:0] hc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [15:0] conv(input logic [7:0] b, input logic en);
    return en ? {hc(b[7:4]), hc(b[3:0])} : {b, 8'h00};
  endfunction

  assign conv_ascii   = conv(conv_bin, conv_en);
  assign x_conv_ascii = conv(x_conv_bin, x_conv_en);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int unsigned wa[$], wd[$], xa[$];
  int done_q[$];
  int first_busy, last_busy, busy_n, conv_bad, stall_bad;

  // Cycle c is the period following edge c-1; start is sampled at edge 0.
  task automatic run(input logic hex, input int stall_at, input int restart_at,
                     input int rst_at, input int ncycles);
    wa.delete(); wd.delete(); xa.delete(); done_q.delete();
    first_busy = -1; last_busy = -1; busy_n = 0; conv_bad = 0; stall_bad = 0;
    @(negedge clk);
    hex_en = hex;
    start  = 1'b1;
    for (int c = 1; c <= ncycles; c++) begin
      @(negedge clk);
      start      = (c == restart_at);
      char_ready = !(stall_at > 0 && c >= stall_at && c < stall_at + 3);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_char_we", {31'b0, char_we}, 0);
        chk("rst_char_addr", {22'b0, char_addr}, 0);
        chk("rst_char_data", {24'b0, char_data}, 0);
        chk("rst_conv_bin", {24'b0, conv_bin}, 0);
        chk("rst_conv_en", {31'b0, conv_en}, 0);
      end
      if (char_we && char_ready) begin
        wa.push_back(char_addr);
        wd.push_back(char_data);
      end
      if (x_char_we && char_ready) xa.push_back(x_char_addr);
      if (!char_ready && (!char_we || char_addr != 10'd3 || char_data != 8'h34))
        stall_bad++;
      if (done) done_q.push_back(c);
      if (busy) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
        busy_n++;
        if (conv_en != hex) conv_bad++;
      end
    end
    start      = 1'b0;
    char_ready = 1'b1;
  endtask

  logic [7:0] exp_hex [16] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44,
                               8'h30, 8'h30, 8'h46, 8'h46, 8'h30, 8'h41, 8'h35, 8'h45};
  logic [7:0] exp_raw [8]  = '{8'h12, 8'h00, 8'h34, 8'h00, 8'hAB, 8'h00, 8'hCD, 8'h00};
  int unsigned exp_xa [16] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3,
                               12, 13, 14, 15, 16, 17, 18, 19};

  function automatic int unsigned qget(input int unsigned q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD;
  endfunction

  task automatic check_hex_run(input string tag, input int done_cyc);
    int n3;
    chk({tag, "_nwr"}, wa.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), qget(wa, i), (i < 8) ? i : i + 8);
      chk($sformatf("%s_data%0d", tag, i), qget(wd, i), {24'b0, exp_hex[i]});
    end
    n3 = 0;
    foreach (wa[i]) if (wa[i] == 3) n3++;
    chk({tag, "_addr3_once"}, n3, 1);
    chk({tag, "_ndone"}, done_q.size(), 1);
    chk({tag, "_done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, done_cyc);
    chk({tag, "_busy_first"}, first_busy, 1);
    chk({tag, "_busy_last"}, last_busy, done_cyc);
    chk({tag, "_busy_n"}, busy_n, done_cyc);
  endtask

  initial begin
    mem[0] = 32'h1234ABCD;
    mem[1] = 32'h00FF0A5E;
    #1;
    chk("init_busy", {31'b0, busy}, 0);
    chk("init_done", {31'b0, done}, 0);
    chk("init_rd_en", {31'b0, word_rd_en}, 0);
    chk("init_char_we", {31'b0, char_we}, 0);
    chk("init_char_addr", {22'b0, char_addr}, 0);
    chk("init_conv_en", {31'b0, conv_en}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(1'b1, 0, 0, 0, 30);
    check_hex_run("hex", 21);
    chk("hex_conv_en", conv_bad, 0);
    chk("wrap_nwr", xa.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("wrap_addr%0d", i), qget(xa, i), exp_xa[i]);

    run(1'b0, 0, 0, 0, 30);
    chk("raw_nwr", wa.size(), 16);
    for (int i = 0; i < 8; i++)
      chk($sformatf("raw_data%0d", i), qget(wd, i), {24'b0, exp_raw[i]});
    chk("raw_conv_en", conv_bad, 0);
    chk("raw_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 21);

    run(1'b1, 6, 0, 0, 35);
    check_hex_run("stall", 24);
    chk("stall_hold", stall_bad, 0);

    run(1'b1, 0, 5, 0, 30);
    check_hex_run("restart", 21);

    run(1'b1, 0, 0, 7, 30);
    chk("rstmid_nwr", wa.size(), 4);
    chk("rstmid_ndone", done_q.size(), 0);
    chk("rstmid_last_addr", (wa.size() > 0) ? wa[wa.size()-1] : -1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 0, 0, 0, 30);
    check_hex_run("after_rst", 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
